// File: rtl/ibex_rf_access_ctrl.sv
// Register-file access arbiter: post-reset clear sequence, core writeback and a
// single-outstanding debug read/write port sharing one rf write/read port.
module ibex_rf_access_ctrl #(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 core_we_i,
   input  logic [4:0]           core_waddr_i,
   input  logic [DataWidth-1:0] core_wdata_i,
   input  logic                 dbg_req_valid_i,
   output logic                 dbg_req_ready_o,
   input  logic                 dbg_req_write_i,
   input  logic [4:0]           dbg_req_addr_i,
   input  logic [DataWidth-1:0] dbg_req_wdata_i,
   output logic                 dbg_rsp_valid_o,
   output logic                 dbg_rsp_err_o,
   output logic [DataWidth-1:0] dbg_rsp_rdata_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic [4:0]           rf_raddr_o,
   input  logic [DataWidth-1:0] rf_rdata_i,
   output logic                 busy_o
);

   localparam int unsigned NumWords = RV32E ? 16 : 32;
   localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

   typedef enum logic [1:0] {StClear, StIdle, StRsp} state_e;

   state_e               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 core_wr;
   logic                 dbg_oob;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rsp_valid_d     = 1'b0;
      rsp_err_d       = rsp_err_q;
      rsp_rdata_d     = rsp_rdata_q;
      rf_we_o         = 1'b0;
      rf_waddr_o      = '0;
      rf_wdata_o      = '0;
      rf_raddr_o      = '0;
      dbg_req_ready_o = 1'b0;
      core_wr         = core_we_i && (core_waddr_i != '0);
      dbg_oob         = RV32E && dbg_req_addr_i[4];

      case (state_q)
         StClear: begin
            // Any core write request (even to x0) pauses the clear for that cycle.
            if (!core_we_i) begin
               rf_we_o    = 1'b1;
               rf_waddr_o = cnt_q;
               rf_wdata_o = WordZeroVal;
               if (cnt_q == LastAddr) state_d = StIdle;
               else                   cnt_d   = cnt_q + 5'd1;
            end
         end
         StIdle: begin
            dbg_req_ready_o = !core_we_i;
            if (dbg_req_valid_i && !core_we_i) begin
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = dbg_oob;
               rsp_rdata_d = '0;
               if (!dbg_oob) begin
                  if (dbg_req_write_i) begin
                     if (dbg_req_addr_i != '0) begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = dbg_req_addr_i;
                        rf_wdata_o = dbg_req_wdata_i;
                     end
                  end else begin
                     rf_raddr_o  = dbg_req_addr_i;
                     rsp_rdata_d = rf_rdata_i;
                  end
               end
            end
         end
         StRsp:   state_d = StIdle;
         default: state_d = StClear;
      endcase

      if (core_wr) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = core_waddr_i;
         rf_wdata_o = core_wdata_i;
      end

      // Reset masks every port action combinationally, not just the next state.
      if (rst_i) begin
         rf_we_o         = 1'b0;
         rf_waddr_o      = '0;
         rf_wdata_o      = '0;
         rf_raddr_o      = '0;
         dbg_req_ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StClear;
         cnt_q       <= 5'd1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign dbg_rsp_valid_o = rsp_valid_q && !rst_i;
   assign dbg_rsp_err_o   = rsp_err_q;
   assign dbg_rsp_rdata_o = rsp_rdata_q;
   assign busy_o          = (state_q == StClear) || rst_i;

endmodule
